dbg_cmd_sequencer: RTL and testbench
====================================

# dbg_cmd_sequencer

Command sequencer between the UART byte receiver/transmitter and the debug-visible datapath (memory port, run/halt/step control, PC register). Assembles 3-byte frames (cmd, addr, data) from the RX byte stream, executes each command with a fixed cycle sequence, and returns exactly one response byte per frame through the TX handshake. Inter-byte timeout recovers a partially received frame.

## Interface
- ADDR_W, 8: memory address width; frame addr byte zero-extended or truncated to fit
- PC_W, 8: PC width; SET_PC loads addr byte (zero-extended), GET_PC returns pc_val[7:0]
- TIMEOUT_CYCLES, 4096: idle cycles allowed between frame bytes; 0 disables timeout

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- rx_data  in  8  received byte, valid with rx_valid
- rx_valid  in  1  one-cycle pulse per received byte
- tx_data  out  8  response byte, stable from tx_en until tx_done
- tx_en  out  1  one-cycle pulse starting a TX byte
- tx_done  in  1  one-cycle pulse when TX byte finished
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  8  memory write data
- mem_we  out  1  one-cycle write strobe
- mem_re  out  1  one-cycle read strobe; mem_rdata valid next cycle
- mem_rdata  in  8  memory read data
- run  out  1  core run enable (level)
- step_pulse  out  1  one-cycle single-step request
- pc_load  out  1  one-cycle PC load strobe
- pc_wdata  out  PC_W  PC load value
- pc_val  in  PC_W  current PC
- busy  out  1  high whenever state != IDLE
- frame_err  out  1  one-cycle pulse on timeout abort or dropped byte

## Operation
- Commands: PING 0x01, WRITE 0x02, READ 0x03, RUN 0x04, HALT 0x05, STEP 0x06, SET_PC 0x07, GET_PC 0x08; any other value is unknown.
- Responses: PING -> 0xA5; WRITE/RUN/HALT/SET_PC/successful STEP -> ACK 0x06; READ -> mem_rdata; GET_PC -> pc_val[7:0]; unknown cmd or STEP while run=1 -> NAK 0x15.
- States: IDLE -> GET_ADDR -> GET_DATA -> EXEC -> (MEM_WAIT for READ only) -> RESP -> TX_WAIT -> IDLE.
- IDLE/GET_ADDR/GET_DATA: each rx_valid latches byte into cmd/addr/data and advances. Full frame always collected, even for unknown cmd.
- EXEC (one cycle): WRITE mem_we=1, mem_addr=addr, mem_wdata=data; READ mem_re=1; RUN run<=1; HALT run<=0; STEP step_pulse=1 if run=0; SET_PC pc_load=1, pc_wdata=addr. PING/GET_PC/unknown: no side effect.
- MEM_WAIT: capture mem_rdata into response register.
- RESP: tx_en=1 for one cycle with tx_data = response. TX_WAIT: hold tx_data until tx_done, then IDLE.
- RUN when already running, HALT when halted: no change, ACK.
- rx_valid in EXEC/MEM_WAIT/RESP/TX_WAIT: byte dropped, frame_err pulsed; frame in progress unaffected.
- Timeout: counter cleared on every accepted byte; in GET_ADDR/GET_DATA, after TIMEOUT_CYCLES cycles with no rx_valid -> IDLE, frame_err pulse, no response, no side effects.

## Timing
- Reset values: state IDLE, run=0, tx_en=0, tx_data=0x00, mem_we=mem_re=0, mem_addr=0, mem_wdata=0, step_pulse=0, pc_load=0, pc_wdata=0, busy=0, frame_err=0. Reset mid-frame discards frame; run drops to 0 immediately (async).
- Third byte accepted at edge T: EXEC strobes in cycle T+1; non-READ tx_en in T+2; READ mem_re in T+1, capture T+2, tx_en in T+3.
- tx_done in cycle U (TX_WAIT) -> IDLE at U+1; a rx_valid in U+1 is accepted as new cmd byte.
- tx_done outside TX_WAIT ignored.
- rx_valid in same cycle as timeout expiry: byte accepted, no timeout.
- All strobes (mem_we, mem_re, step_pulse, pc_load, tx_en, frame_err) exactly one cycle wide, registered outputs.
- busy rises the cycle after the cmd byte is accepted.

## Test plan
- Reset: hold rst_n=0 -> all outputs at reset values; release, send PING 01 00 00 -> tx_en one pulse with tx_data=0xA5 two cycles after third byte.
- WRITE 02 10 5A then READ 03 10 00 (bench memory model) -> mem_we at addr 0x10 data 0x5A, ACK 0x06; then mem_re, response 0x5A, tx_en three cycles after third byte.
- RUN 04, STEP 06 -> run=1, ACK, then NAK 0x15 with no step_pulse; HALT 05, STEP 06 -> run=0, ACK, one step_pulse, ACK.
- SET_PC 07 79 00 -> pc_load pulse with pc_wdata=0x79, ACK; GET_PC with pc_val=0x79 -> response 0x79.
- Timeout (TIMEOUT_CYCLES=32): send 02 10 then silence -> frame_err pulse after 32 cycles, no mem_we, no tx_en; next PING frame answered 0xA5.
- Unknown cmd 0xFF 00 00 -> NAK 0x15; extra byte sent while in TX_WAIT -> frame_err pulse, dropped, response unchanged.

Source files
------------

// File: rtl/dbg_cmd_sequencer.sv
// Debug command sequencer: collects cmd/addr/data frames from the UART RX stream,
// runs each command against the memory/run/PC controls and returns one response byte.
module dbg_cmd_sequencer #(
    parameter int ADDR_W         = 8,
    parameter int PC_W           = 8,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic [7:0]        tx_data,
    output logic              tx_en,
    input  logic              tx_done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [7:0]        mem_rdata,
    output logic              run,
    output logic              step_pulse,
    output logic              pc_load,
    output logic [PC_W-1:0]   pc_wdata,
    input  logic [PC_W-1:0]   pc_val,
    output logic              busy,
    output logic              frame_err
);

    typedef enum logic [2:0] {
        S_IDLE, S_GET_ADDR, S_GET_DATA, S_EXEC, S_MEM_WAIT, S_RESP, S_TX_WAIT
    } state_e;

    localparam logic [7:0] CMD_PING = 8'h01, CMD_WRITE = 8'h02, CMD_READ  = 8'h03,
                           CMD_RUN  = 8'h04, CMD_HALT  = 8'h05, CMD_STEP  = 8'h06,
                           CMD_SETPC = 8'h07, CMD_GETPC = 8'h08;
    localparam logic [7:0] RSP_PING = 8'hA5, RSP_ACK = 8'h06, RSP_NAK = 8'h15;
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

    state_e              state_q, state_d;
    logic [7:0]          cmd_q, cmd_d, addr_q, addr_d;
    logic [31:0]         tmo_q, tmo_d;
    logic                run_q, run_d, tx_en_q, tx_en_d, mem_we_q, mem_we_d, mem_re_q, mem_re_d;
    logic                step_q, step_d, pc_load_q, pc_load_d, frame_err_q, frame_err_d;
    logic [7:0]          tx_data_q, tx_data_d, mem_wdata_q, mem_wdata_d, resp;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [PC_W-1:0]     pc_wdata_q, pc_wdata_d;
    logic                waiting, expire, fire;

    assign waiting = (state_q == S_GET_ADDR) || (state_q == S_GET_DATA);
    assign expire  = waiting && !rx_valid && (TIMEOUT_CYCLES != 0) && (tmo_q == TMO_LAST);
    // Side effects are registered off the third-byte edge so they land in the EXEC cycle.
    assign fire    = (state_q == S_GET_DATA) && rx_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (rx_valid) state_d = S_GET_ADDR;
            S_GET_ADDR: if (rx_valid) state_d = S_GET_DATA; else if (expire) state_d = S_IDLE;
            S_GET_DATA: if (rx_valid) state_d = S_EXEC;     else if (expire) state_d = S_IDLE;
            S_EXEC:     state_d = (cmd_q == CMD_READ) ? S_MEM_WAIT : S_RESP;
            S_MEM_WAIT: state_d = S_RESP;
            S_RESP:     state_d = S_TX_WAIT;
            S_TX_WAIT:  if (tx_done) state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    always_comb begin
        resp = RSP_NAK;
        case (cmd_q)
            CMD_PING:                                 resp = RSP_PING;
            CMD_WRITE, CMD_RUN, CMD_HALT, CMD_SETPC:  resp = RSP_ACK;
            CMD_STEP:                                 resp = run_q ? RSP_NAK : RSP_ACK;
            CMD_GETPC:                                resp = 8'(pc_val);
            default:                                  resp = RSP_NAK;
        endcase
    end

    always_comb begin
        cmd_d       = cmd_q;
        addr_d      = addr_q;
        tmo_d       = (waiting && !rx_valid) ? tmo_q + 32'd1 : '0;
        run_d       = run_q;
        tx_en_d     = 1'b0;
        tx_data_d   = tx_data_q;
        mem_we_d    = 1'b0;
        mem_re_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        step_d      = 1'b0;
        pc_load_d   = 1'b0;
        pc_wdata_d  = pc_wdata_q;
        frame_err_d = expire;
        if (rx_valid) begin
            case (state_q)
                S_IDLE:     cmd_d  = rx_data;
                S_GET_ADDR: addr_d = rx_data;
                S_GET_DATA: ;
                default:    frame_err_d = 1'b1;
            endcase
        end
        if (fire) begin
            case (cmd_q)
                CMD_WRITE: begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = ADDR_W'(addr_q);
                    mem_wdata_d = rx_data;
                end
                CMD_READ: begin
                    mem_re_d   = 1'b1;
                    mem_addr_d = ADDR_W'(addr_q);
                end
                CMD_RUN:   run_d  = 1'b1;
                CMD_HALT:  run_d  = 1'b0;
                CMD_STEP:  step_d = !run_q;
                CMD_SETPC: begin
                    pc_load_d  = 1'b1;
                    pc_wdata_d = PC_W'(addr_q);
                end
                default: ;
            endcase
        end
        if (state_q == S_EXEC && cmd_q != CMD_READ) begin
            tx_en_d   = 1'b1;
            tx_data_d = resp;
        end
        if (state_q == S_MEM_WAIT) begin
            tx_en_d   = 1'b1;
            tx_data_d = mem_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q <= '0; addr_q <= '0; tmo_q <= '0; run_q <= 1'b0;
            tx_en_q <= 1'b0; tx_data_q <= '0; mem_we_q <= 1'b0; mem_re_q <= 1'b0;
            mem_addr_q <= '0; mem_wdata_q <= '0; step_q <= 1'b0; pc_load_q <= 1'b0;
            pc_wdata_q <= '0; frame_err_q <= 1'b0;
        end else begin
            cmd_q <= cmd_d; addr_q <= addr_d; tmo_q <= tmo_d; run_q <= run_d;
            tx_en_q <= tx_en_d; tx_data_q <= tx_data_d; mem_we_q <= mem_we_d; mem_re_q <= mem_re_d;
            mem_addr_q <= mem_addr_d; mem_wdata_q <= mem_wdata_d; step_q <= step_d;
            pc_load_q <= pc_load_d; pc_wdata_q <= pc_wdata_d; frame_err_q <= frame_err_d;
        end
    end

    assign tx_data    = tx_data_q;
    assign tx_en      = tx_en_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_we     = mem_we_q;
    assign mem_re     = mem_re_q;
    assign run        = run_q;
    assign step_pulse = step_q;
    assign pc_load    = pc_load_q;
    assign pc_wdata   = pc_wdata_q;
    assign busy       = (state_q != S_IDLE);
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_dbg_cmd_sequencer.sv
// Directed bench for dbg_cmd_sequencer: response scoreboard, memory/PC model, strobe monitor.
module tb_dbg_cmd_sequencer;

    logic       clk = 1'b0, rst_n = 1'b0;
    logic [7:0] rx_data, tx_data, mem_wdata, mem_rdata;
    logic       rx_valid, tx_en, tx_done, mem_we, mem_re, run, step_pulse, pc_load, busy, frame_err;
    logic [7:0] mem_addr, pc_wdata, pc_val;

    dbg_cmd_sequencer #(.ADDR_W(8), .PC_W(8), .TIMEOUT_CYCLES(32)) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_en(tx_en), .tx_done(tx_done),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
        .mem_rdata(mem_rdata), .run(run), .step_pulse(step_pulse), .pc_load(pc_load),
        .pc_wdata(pc_wdata), .pc_val(pc_val), .busy(busy), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    typedef struct { logic [7:0] data; int cyc; } exp_t;
    exp_t sb[$];
    exp_t mon_e;
    int tests = 0, fails = 0, cyc = 0;
    int n_tx = 0, n_we = 0, n_re = 0, n_step = 0, n_pcl = 0, n_ferr = 0;
    int we_cyc = 0, re_cyc = 0, step_cyc = 0, ferr_cyc = 0;
    logic [7:0] we_addr = 0, we_data = 0, pcl_val = 0;
    logic [5:0] prev_strb = 0;
    logic [7:0] mem [0:255];

    always @(posedge clk) cyc <= cyc + 1;

    // Memory with one-cycle read latency and a PC register that follows pc_load.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_rdata <= 8'h00;
            pc_val    <= 8'h00;
        end else begin
            if (mem_we)  mem[mem_addr] <= mem_wdata;
            if (mem_re)  mem_rdata <= mem[mem_addr];
            if (pc_load) pc_val <= pc_wdata;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (tx_en) begin
                n_tx++;
                if (sb.size() == 0) chk("tx_unexpected", 32'd1, 32'd0);
                else begin
                    mon_e = sb.pop_front();
                    chk("tx_data", tx_data, mon_e.data);
                    chk("tx_en_cycle", cyc, mon_e.cyc);
                end
            end
            if (mem_we)     begin n_we++; we_cyc = cyc; we_addr = mem_addr; we_data = mem_wdata; end
            if (mem_re)     begin n_re++; re_cyc = cyc; end
            if (step_pulse) begin n_step++; step_cyc = cyc; end
            if (pc_load)    begin n_pcl++; pcl_val = pc_wdata; end
            if (frame_err)  begin n_ferr++; ferr_cyc = cyc; end
            if ({tx_en, mem_we, mem_re, step_pulse, pc_load, frame_err} != 6'b0)
                chk("strobe_width", {26'b0, prev_strb & {tx_en, mem_we, mem_re, step_pulse, pc_load, frame_err}}, 32'd0);
            prev_strb = {tx_en, mem_we, mem_re, step_pulse, pc_load, frame_err};
        end else prev_strb = 6'b0;
    end

    task automatic send_byte(input logic [7:0] b, input bit now);
        if (!now) @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    // tacc = cycle index of the period following the third-byte edge; tx_en expected at tacc+off.
    task automatic send_frame(input logic [7:0] c, input logic [7:0] a, input logic [7:0] d,
                              input logic [7:0] rsp, input int off, input bit now, output int tacc);
        exp_t e;
        send_byte(c, now);
        send_byte(a, 1'b0);
        send_byte(d, 1'b0);
        tacc   = cyc;
        e.data = rsp;
        e.cyc  = cyc + off;
        sb.push_back(e);
    endtask

    task automatic wait_tx();
        for (int i = 0; i < 12 && sb.size() != 0; i++) @(negedge clk);
        chk("tx_seen", sb.size(), 0);
    endtask

    task automatic finish_tx();
        wait_tx();
        @(negedge clk) tx_done = 1'b1;
        @(negedge clk) tx_done = 1'b0;
        chk("idle_after_done", {31'b0, busy}, 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, c0, c1, d;
        rx_data = 8'h00; rx_valid = 1'b0; tx_done = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_strobes", {24'b0, run, tx_en, mem_we, mem_re, step_pulse, pc_load, busy, frame_err}, 32'd0);
        chk("rst_tx_data", tx_data, 32'h00);
        chk("rst_mem_addr", mem_addr, 32'h00);
        chk("rst_mem_wdata", mem_wdata, 32'h00);
        chk("rst_pc_wdata", pc_wdata, 32'h00);
        rst_n = 1'b1;

        send_frame(8'h01, 8'h00, 8'h00, 8'hA5, 1, 1'b0, t);
        chk("busy_ping", {31'b0, busy}, 32'd1);
        finish_tx();

        c0 = n_we;
        send_frame(8'h02, 8'h10, 8'h5A, 8'h06, 1, 1'b0, t);
        wait_tx();
        chk("we_count", n_we, c0 + 1);
        chk("we_cycle", we_cyc, t);
        chk("we_addr", we_addr, 32'h10);
        chk("we_data", we_data, 32'h5A);
        finish_tx();

        c0 = n_re;
        send_frame(8'h03, 8'h10, 8'h00, 8'h5A, 2, 1'b0, t);
        wait_tx();
        chk("re_count", n_re, c0 + 1);
        chk("re_cycle", re_cyc, t);
        finish_tx();

        send_frame(8'h04, 8'h00, 8'h00, 8'h06, 1, 1'b0, t);
        finish_tx();
        chk("run_set", {31'b0, run}, 32'd1);
        c0 = n_step;
        send_frame(8'h06, 8'h00, 8'h00, 8'h15, 1, 1'b0, t);
        finish_tx();
        chk("step_while_run", n_step, c0);
        send_frame(8'h04, 8'h00, 8'h00, 8'h06, 1, 1'b0, t);
        finish_tx();
        chk("run_again", {31'b0, run}, 32'd1);
        send_frame(8'h05, 8'h00, 8'h00, 8'h06, 1, 1'b0, t);
        finish_tx();
        chk("run_cleared", {31'b0, run}, 32'd0);
        send_frame(8'h05, 8'h00, 8'h00, 8'h06, 1, 1'b0, t);
        finish_tx();
        send_frame(8'h06, 8'h00, 8'h00, 8'h06, 1, 1'b0, t);
        finish_tx();
        chk("step_count", n_step, c0 + 1);
        chk("step_cycle", step_cyc, t);

        c0 = n_pcl;
        send_frame(8'h07, 8'h79, 8'h00, 8'h06, 1, 1'b0, t);
        finish_tx();
        chk("pcl_count", n_pcl, c0 + 1);
        chk("pcl_value", pcl_val, 32'h79);
        // First byte of GET_PC lands in the cycle right after tx_done.
        send_frame(8'h08, 8'h00, 8'h00, 8'h79, 1, 1'b1, t);
        finish_tx();

        c0 = n_ferr; c1 = n_we; d = n_tx;
        send_byte(8'h02, 1'b0);
        send_byte(8'h10, 1'b0);
        t = cyc;
        repeat (30) @(negedge clk);
        chk("tmo_not_early", n_ferr, c0);
        chk("tmo_busy_wait", {31'b0, busy}, 32'd1);
        repeat (5) @(negedge clk);
        chk("tmo_ferr", n_ferr, c0 + 1);
        chk("tmo_cycle", {31'b0, (ferr_cyc - t >= 32) && (ferr_cyc - t <= 33)}, 32'd1);
        chk("tmo_idle", {31'b0, busy}, 32'd0);
        chk("tmo_no_we", n_we, c1);
        chk("tmo_no_tx", n_tx, d);
        send_frame(8'h01, 8'h00, 8'h00, 8'hA5, 1, 1'b0, t);
        finish_tx();

        send_frame(8'hFF, 8'h00, 8'h00, 8'h15, 1, 1'b0, t);
        wait_tx();
        c0 = n_ferr;
        send_byte(8'h01, 1'b0);
        @(negedge clk);
        chk("drop_ferr", n_ferr, c0 + 1);
        chk("drop_tx_hold", tx_data, 32'h15);
        chk("drop_busy", {31'b0, busy}, 32'd1);
        finish_tx();
        send_frame(8'h01, 8'h00, 8'h00, 8'hA5, 1, 1'b0, t);
        finish_tx();

        send_frame(8'h04, 8'h00, 8'h00, 8'h06, 1, 1'b0, t);
        finish_tx();
        send_byte(8'h02, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_run_drop", {31'b0, run}, 32'd0);
        chk("async_busy_drop", {31'b0, busy}, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        send_frame(8'h01, 8'h00, 8'h00, 8'hA5, 1, 1'b0, t);
        finish_tx();
        repeat (3) @(negedge clk);
        chk("sb_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
